// File: rtl/led_panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_panel_pkg
// Description : Shared constants for the led_panel peripheral: register
//               offsets within the bus window and register reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package led_panel_pkg;

    // Register offsets from BASE_ADDR
    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_BRIGHT = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    // Register reset values
    localparam logic [7:0] LED_RST    = 8'h00;
    localparam logic [7:0] BRIGHT_RST = 8'hFF;
    localparam logic [7:0] CTRL_RST   = 8'h01;

endpackage : led_panel_pkg
`default_nettype wire

// File: rtl/led_pwm.sv
`default_nettype none
// ============================================================================
// Module      : led_pwm
// Description : 8-bit free-running counter with duty comparator. The output
//               is high while the counter is below the duty value; a duty of
//               8'hFF forces the output permanently high so full brightness
//               has no dark slot.
// Ports       : clock  - system clock
//               reset  - asynchronous active-low reset (clears the counter)
//               duty   - PWM duty, 0 = always off, 8'hFF = always on
//               on     - PWM gate, combinational from counter and duty
// Revision    : 1.0 - initial release
// ============================================================================
module led_pwm (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       on
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Natural 8-bit wrap gives the 256-clock period with no special case.
    assign cnt_d = cnt_q + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign on = (duty == 8'hFF) | (cnt_q < duty);

endmodule : led_pwm
`default_nettype wire

// File: rtl/led_panel.sv
`default_nettype none
// ============================================================================
// Module      : led_panel
// Description : Memory-mapped 8-LED output peripheral on the CPU6 bus.
//               Three-register window at BASE_ADDR: LED pattern (+0),
//               BRIGHT PWM duty (+1), CTRL global enable (+2, bit 0).
//               Reads are combinational and gated by sel.
// Config      : Define LED_PANEL_PWM_EN to build the BRIGHT register and
//               the led_pwm dimmer. Without it, +1 is decoded but reads 0,
//               ignores writes, and the LEDs are never dimmed.
// Ports       : clock    - system clock
//               reset    - asynchronous active-low reset
//               address  - CPU6 address bus (19 bits, fully decoded)
//               write_en - write strobe, active-high
//               data_in  - write data
//               data_out - read data, 8'h00 when not selected
//               sel      - address hits the register window
//               leds     - LED pins, bit 7 = LED1 ... bit 0 = LED8
// Revision    : 1.0 - initial release
// ============================================================================
module led_panel
    import led_panel_pkg::*;
#(
    parameter logic [18:0] BASE_ADDR      = 19'h0F110,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [18:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        sel,
    output logic [7:0]  leds
);

    logic [18:0] w_offset;
    logic [1:0]  w_reg;
    logic        w_wr;
    logic        w_pwm_on;
    logic [7:0]  w_bright;
    logic [7:0]  w_lit;

    logic [7:0]  led_q;
    logic [7:0]  led_d;
    logic        ctrl_en_q;
    logic        ctrl_en_d;

    // ------------------------------------------------------------------------
    // Decode: modular subtraction then a range check covers the whole window
    // with every address bit participating, so there is no aliasing.
    // ------------------------------------------------------------------------
    assign w_offset = address - BASE_ADDR;
    assign sel      = (w_offset < 19'd3);
    assign w_reg    = w_offset[1:0];
    assign w_wr     = write_en & sel;

    always_comb begin
        led_d     = led_q;
        ctrl_en_d = ctrl_en_q;
        if (w_wr) begin
            case (w_reg)
                OFF_LED:  led_d     = data_in;
                OFF_CTRL: ctrl_en_d = data_in[0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            led_q     <= LED_RST;
            ctrl_en_q <= CTRL_RST[0];
        end else begin
            led_q     <= led_d;
            ctrl_en_q <= ctrl_en_d;
        end
    end

    // ------------------------------------------------------------------------
    // Optional PWM dimming
    // ------------------------------------------------------------------------
`ifdef LED_PANEL_PWM_EN
    logic [7:0] bright_q;
    logic [7:0] bright_d;

    always_comb begin
        bright_d = bright_q;
        if (w_wr && (w_reg == OFF_BRIGHT)) begin
            bright_d = data_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bright_q <= BRIGHT_RST;
        end else begin
            bright_q <= bright_d;
        end
    end

    led_pwm u_pwm (
        .clock (clock),
        .reset (reset),
        .duty  (bright_q),
        .on    (w_pwm_on)
    );

    assign w_bright = bright_q;
`else
    assign w_pwm_on = 1'b1;
    assign w_bright = 8'h00;
`endif

    // ------------------------------------------------------------------------
    // Combinational read path
    // ------------------------------------------------------------------------
    always_comb begin
        data_out = 8'h00;
        if (sel) begin
            case (w_reg)
                OFF_LED:    data_out = led_q;
                OFF_BRIGHT: data_out = w_bright;
                OFF_CTRL:   data_out = {7'b0, ctrl_en_q};
                default:    data_out = 8'h00;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // LED output path
    // ------------------------------------------------------------------------
    assign w_lit = led_q & {8{ctrl_en_q & w_pwm_on}};

    generate
        if (LED_ACTIVE_LOW) begin : g_active_low
            assign leds = ~w_lit;
        end else begin : g_active_high
            assign leds = w_lit;
        end
    endgenerate

endmodule : led_panel
`default_nettype wire

// File: tb/tb_led_panel.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_panel
// Description : Self-checking bench for led_panel (LED_ACTIVE_LOW = 1).
//               Expected values go into a scoreboard queue when stimulus is
//               applied and are popped when the DUT output is sampled.
//               PWM checks are built only when LED_PANEL_PWM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_panel;

    localparam logic [18:0] C_BASE = 19'h0F110;

    logic        clock;
    logic        reset;
    logic [18:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        sel;
    logic [7:0]  leds;

    int          checks;
    int          errors;
    logic [15:0] exp_q[$];
    logic [7:0]  model_led;

    led_panel #(
        .BASE_ADDR      (C_BASE),
        .LED_ACTIVE_LOW (1'b1)
    ) u_dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .sel      (sel),
        .leds     (leds)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Global time bound
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_pop_check(input string tag, input logic [15:0] got);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got %0h expected scoreboard entry", tag, got);
        end else begin
            e = exp_q.pop_front();
            check_value(tag, got, e);
        end
    endtask

    task automatic bus_write(input logic [18:0] a, input logic [7:0] d);
        @(negedge clock);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(posedge clock);
        #1;
        write_en = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [18:0] a,
                            input logic [7:0] exp_data, input logic exp_sel);
        address  = a;
        write_en = 1'b0;
        sb_push({8'h00, exp_data});
        sb_push({15'h0, exp_sel});
        @(negedge clock);
        sb_pop_check({tag, "_data"}, {8'h00, data_out});
        sb_pop_check({tag, "_sel"}, {15'h0, sel});
    endtask

    task automatic leds_check(input string tag, input logic [7:0] exp_pins);
        sb_push({8'h00, exp_pins});
        @(negedge clock);
        sb_pop_check(tag, {8'h00, leds});
    endtask

`ifdef LED_PANEL_PWM_EN
    task automatic pwm_count(input string tag, input logic [7:0] duty, input int exp_lit);
        int lit_cnt;
        int other_bad;
        bus_write(C_BASE + 19'd1, duty);
        sb_push(exp_lit[15:0]);
        sb_push(16'h0);
        lit_cnt   = 0;
        other_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            if (leds[0] == 1'b0) lit_cnt++;
            if (leds[7:1] != 7'h7F) other_bad++;
        end
        sb_pop_check({tag, "_lit"}, lit_cnt[15:0]);
        sb_pop_check({tag, "_others"}, other_bad[15:0]);
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        address  = '0;
        write_en = 1'b0;
        data_in  = 8'h00;

        // ---------------- reset state ----------------
        leds_check("rst_leds", 8'hFF);
        bus_read("rst_led", C_BASE, 8'h00, 1'b1);
`ifdef LED_PANEL_PWM_EN
        bus_read("rst_bright", C_BASE + 19'd1, 8'hFF, 1'b1);
`else
        bus_read("rst_bright", C_BASE + 19'd1, 8'h00, 1'b1);
`endif
        bus_read("rst_ctrl", C_BASE + 19'd2, 8'h01, 1'b1);
        @(negedge clock);
        reset = 1'b1;

        // ---------------- basic write ----------------
        bus_write(C_BASE, 8'hA5);
        leds_check("wr_leds", 8'h5A);
        bus_read("wr_led", C_BASE, 8'hA5, 1'b1);

        // ---------------- decode ----------------
        bus_write(C_BASE + 19'd3, 8'hFF);
        bus_write(C_BASE ^ 19'h40000, 8'hFF);
        bus_write(C_BASE - 19'd1, 8'hFF);
        bus_read("dec_led", C_BASE, 8'hA5, 1'b1);
        bus_read("dec_off3", C_BASE + 19'd3, 8'h00, 1'b0);
        bus_read("dec_alias", C_BASE ^ 19'h40000, 8'h00, 1'b0);
        bus_read("dec_below", C_BASE - 19'd1, 8'h00, 1'b0);
        leds_check("dec_leds", 8'h5A);

        // ---------------- enable ----------------
        bus_write(C_BASE + 19'd2, 8'h00);
        leds_check("en_off", 8'hFF);
        bus_write(C_BASE + 19'd2, 8'h01);
        leds_check("en_on", 8'h5A);
        bus_write(C_BASE + 19'd2, 8'hFE);
        bus_read("ctrl_fe", C_BASE + 19'd2, 8'h00, 1'b1);
        leds_check("ctrl_fe_leds", 8'hFF);
        bus_write(C_BASE + 19'd2, 8'h01);

        // ---------------- read during write ----------------
        @(negedge clock);
        address  = C_BASE;
        data_in  = 8'h3C;
        write_en = 1'b1;
        sb_push(16'h00A5);
        #1;
        sb_pop_check("rdw_old", {8'h00, data_out});
        @(posedge clock);
        #1;
        write_en = 1'b0;
        bus_read("rdw_new", C_BASE, 8'h3C, 1'b1);
        leds_check("rdw_leds", 8'hC3);

        // ---------------- BRIGHT / PWM ----------------
`ifdef LED_PANEL_PWM_EN
        bus_write(C_BASE, 8'h01);
        pwm_count("pwm40", 8'h40, 64);
        bus_read("bright_rd", C_BASE + 19'd1, 8'h40, 1'b1);
        pwm_count("pwm00", 8'h00, 0);
        pwm_count("pwmff", 8'hFF, 256);
`else
        bus_write(C_BASE + 19'd1, 8'h55);
        bus_read("bright_off", C_BASE + 19'd1, 8'h00, 1'b1);
        leds_check("bright_off_leds", 8'hC3);
`endif

        // ---------------- async reset during write ----------------
        bus_write(C_BASE, 8'h81);
        @(negedge clock);
        address  = C_BASE;
        data_in  = 8'h77;
        write_en = 1'b1;
        #2;
        reset = 1'b0;
        sb_push(16'h00FF);
        #1;
        sb_pop_check("arst_leds", {8'h00, leds});
        @(posedge clock);
        @(negedge clock);
        write_en = 1'b0;
        reset    = 1'b1;
        bus_read("arst_led", C_BASE, 8'h00, 1'b1);
        bus_read("arst_ctrl", C_BASE + 19'd2, 8'h01, 1'b1);

        // ---------------- random patterns ----------------
        for (int i = 0; i < 8; i++) begin
            model_led = 8'($urandom_range(0, 255));
            bus_write(C_BASE, model_led);
            leds_check("rnd_leds", ~model_led);
            bus_read("rnd_led", C_BASE, model_led, 1'b1);
        end

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_panel
`default_nettype wire

// File: doc/led_panel.md
# led_panel

Memory-mapped 8-LED output peripheral on the CPU6 system bus, alongside the block RAM. It decodes CPU6 bus writes to a small register window, latches an LED pattern and drives the board LED pins. Optional PWM dimming is available. It also returns register contents on a selected read path, which the top level muxes onto the CPU read bus.

## Interface
Parameters:
- `BASE_ADDR`, default 19'h0F110: address of register 0; the window covers BASE_ADDR..BASE_ADDR+2.
- `LED_ACTIVE_LOW`, default 1: when 1, the `leds` pins are inverted (the board LEDs are lit low).

Ports:
- `clock`  in  1: system clock (the divided CPU clock).
- `reset`  in  1: reset, asynchronous and active-low.
- `address`  in  19: CPU6 address bus.
- `write_en`  in  1: CPU6 write strobe, active-high.
- `data_in`  in  8: CPU-to-memory write data.
- `data_out`  out  8: register read data; 8'h00 when not selected.
- `sel`  out  1: high when `address` hits the register window; used by the top level to mux `data_out` over RAM data.
- `leds`  out  8: LED pins; bit 7 is LED1, bit 0 is LED8.

## Operation
Register map (offset from BASE_ADDR):
- +0 LED: 8-bit pattern, read/write; reset value 8'h00.
- +1 BRIGHT: 8-bit PWM duty, read/write; reset value 8'hFF. Present only with the PWM macro defined.
- +2 CTRL: bit0 = global enable, reset value 1. Bits 7:1 read as 0 and ignore writes.

Address decode and access:
- Decode compares all 19 address bits; there is no aliasing.
- Offsets +3 and above are outside the window: `sel`=0.
- Write: on a rising `clock` edge with `write_en`=1 and an address hit, the addressed register takes `data_in`. Writes with no hit are ignored.
- Read: combinational. If `sel`=1, `data_out` is the addressed register; otherwise `data_out`=8'h00.

LED output path:
- `lit[i]` = LED[i] & CTRL[0] & pwm_on.
- `leds` = `lit` when LED_ACTIVE_LOW=0, and ~`lit` when LED_ACTIVE_LOW=1.
- Without PWM, pwm_on = 1.

PWM:
- An 8-bit free-running counter, cnt, increments every clock.
- pwm_on = (BRIGHT == 8'hFF) | (cnt < BRIGHT). So 8'h00 is always off and 8'hFF is always on.
- A BRIGHT write takes effect from the next comparison; cnt is not reset by the write.

Reset:
- Asserting `reset` (low) asynchronously forces LED=0, BRIGHT=FF, CTRL=01 and cnt=0.
- At reset, `leds` = 8'hFF when LED_ACTIVE_LOW=1, and 8'h00 otherwise.
- Reset asserted in the middle of a write discards that write.

## Timing
- Write latency: the register updates at the sampling edge, and `leds` reflects the new value immediately after that edge (registered source, combinational output path).
- `data_out` and `sel` have zero latency from `address`.
- Read-during-write to the same register in one cycle returns the old value; the new value is visible after the edge.
- PWM period is 256 clocks, with no glitch on counter wrap from FF to 00.
- Deassertion of `reset` is used synchronously by the top level. The block samples it asynchronously and needs no synchronizer inside.

## Configuration
- `LED_PANEL_PWM_EN` defined: BRIGHT register, cnt and comparator are built.
- `LED_PANEL_PWM_EN` undefined: offset +1 is still decoded (`sel`=1) but reads 8'h00 and ignores writes, and pwm_on is tied to 1.

## Structure
- Package `led_panel_pkg` holds:
  - register offset constants `OFF_LED`=0, `OFF_BRIGHT`=1, `OFF_CTRL`=2;
  - reset constants `LED_RST`=8'h00, `BRIGHT_RST`=8'hFF, `CTRL_RST`=8'h01.
- One sub-module, `led_pwm`: 8-bit counter plus duty comparator with inputs clock, reset, duty[7:0] and output `on`. It is instantiated only under `LED_PANEL_PWM_EN`.

## Test plan
- Reset: hold `reset`=0 with LED_ACTIVE_LOW=1 -> `leds`=8'hFF. Read +0/+1/+2 -> 00/FF/01.
- Write: write 8'hA5 to BASE_ADDR -> `leds`=8'h5A after the edge, and a read of +0 returns A5 with `sel`=1.
- Decode: write 8'hFF to BASE_ADDR+3 and to BASE_ADDR^19'h40000 -> LED register unchanged, `sel`=0, `data_out`=00.
- Enable: write CTRL=00 with LED=A5 -> `leds`=FF (all off). Write CTRL=01 -> `leds`=5A again. Reading CTRL after writing FE returns 00.
- PWM (macro on): LED=01, BRIGHT=8'h40 -> LED8 lit for exactly 64 of every 256 clocks. BRIGHT=00 -> never lit. BRIGHT=FF -> always lit.
- Async reset during a write: drop `reset` in the middle of a cycle while `write_en`=1 to BASE_ADDR -> `leds` goes to FF before the next edge, and LED reads 00 after release.
